// File: rtl/tawas_rcn_issue_buf_pkg.sv
// Shared tawas_rcn ring word definitions.
// Field layout and request entry used by every ring node.
package tawas_rcn_issue_buf_pkg;

    localparam int RCN_W = 69;

    // Ring word, MSB first: valid, pending, wr, id, seq, mask, addr[23:2], data
    typedef struct packed {
        logic        valid;
        logic        pending;
        logic        wr;
        logic [2:0]  id;
        logic [4:0]  seq;
        logic [3:0]  mask;
        logic [21:0] addr;
        logic [31:0] data;
    } rcn_t;

    // Queued request as held in the issue FIFO
    typedef struct packed {
        logic        wr;
        logic [4:0]  seq;
        logic [3:0]  mask;
        logic [21:0] addr;
        logic [31:0] data;
    } req_t;

    localparam int REQ_W = $bits(req_t);

    function automatic rcn_t req_to_rcn(req_t r, logic [2:0] id);
        rcn_t w;
        w.valid   = 1'b1;
        w.pending = 1'b1;
        w.wr      = r.wr;
        w.id      = id;
        w.seq     = r.seq;
        w.mask    = r.mask;
        w.addr    = r.addr;
        w.data    = r.data;
        return w;
    endfunction

endpackage

// File: rtl/tawas_rcn_issue_buf_fifo.sv
// Issue FIFO for tawas_rcn ring nodes.
// Pushes into a full FIFO are dropped; pointers wrap modulo DEPTH.
module tawas_rcn_fifo #(
    parameter  int WIDTH = 64,
    parameter  int DEPTH = 4,
    localparam int AW    = $clog2(DEPTH),
    localparam int CW    = AW + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    input  logic             pop,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty,
    output logic [CW-1:0]    count
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    rd_ptr;
    logic [AW-1:0]    wr_ptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign dout    = mem[rd_ptr];

    // Pointer and occupancy bookkeeping
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push)
                wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)
                rd_ptr <= rd_ptr + AW'(1);
            if (do_push && !do_pop)
                count <= count + CW'(1);
            else if (do_pop && !do_push)
                count <= count - CW'(1);
        end
    end

    // Entry storage, no reset needed
    always_ff @(posedge clk) begin
        if (do_push)
            mem[wr_ptr] <= din;
    end

endmodule

// File: rtl/tawas_rcn_issue_buf.sv
// Tawas ring node issue buffer.
// Queues requests, inserts them into free ring slots, captures responses.
module tawas_rcn_issue_buf
    import tawas_rcn_issue_buf_pkg::*;
#(
    parameter logic [2:0] MASTER_ID = 3'd0,
    parameter int         DEPTH     = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cs,
    input  logic [4:0]  seq,
    input  logic        wr,
    input  logic [3:0]  mask,
    input  logic [23:0] addr,
    input  logic [31:0] wdata,
    output logic        full,
    output logic        rdone,
    output logic        wdone,
    output logic [4:0]  rsp_seq,
    output logic [3:0]  rsp_mask,
    output logic [23:0] rsp_addr,
    output logic [31:0] rsp_data,
    input  logic [68:0] rcn_in,
    output logic [68:0] rcn_out
);

    localparam int             CW      = $clog2(DEPTH) + 1;
    localparam logic [CW-1:0] FULL_AT = CW'(DEPTH - 1);

    rcn_t          rin;
    req_t          q_din;
    req_t          q_dout;
    logic          q_empty;
    logic          q_full_unused;
    logic [CW-1:0] q_count;
    logic          capture;
    logic          slot_free;
    logic          pop;
    logic          addr_unused;

    assign rin         = rcn_in;
    assign addr_unused = ^addr[1:0];

    assign q_din.wr   = wr;
    assign q_din.seq  = seq;
    assign q_din.mask = mask;
    assign q_din.addr = addr[23:2];
    assign q_din.data = wdata;

    assign capture   = rin.valid && !rin.pending && (rin.id == MASTER_ID);
    assign slot_free = !rin.valid || capture;
    assign pop       = slot_free && !q_empty;
    assign full      = (q_count >= FULL_AT);

    tawas_rcn_fifo #(
        .WIDTH(REQ_W),
        .DEPTH(DEPTH)
    ) u_fifo (
        .clk  (clk),
        .rst  (rst),
        .push (cs),
        .din  (q_din),
        .pop  (pop),
        .dout (q_dout),
        .full (q_full_unused),
        .empty(q_empty),
        .count(q_count)
    );

    // Ring egress: pass foreign traffic, else fill the slot from the FIFO
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            rcn_out <= '0;
        else if (rin.valid && !capture)
            rcn_out <= rcn_in;
        else if (pop)
            rcn_out <= req_to_rcn(q_dout, MASTER_ID);
        else
            rcn_out <= '0;
    end

    // Response capture: done pulses and held response fields
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rdone    <= 1'b0;
            wdone    <= 1'b0;
            rsp_seq  <= '0;
            rsp_mask <= '0;
            rsp_addr <= '0;
            rsp_data <= '0;
        end else begin
            rdone <= capture && !rin.wr;
            wdone <= capture && rin.wr;
            if (capture) begin
                rsp_seq  <= rin.seq;
                rsp_mask <= rin.mask;
                rsp_addr <= {rin.addr, 2'b00};
                rsp_data <= rin.data;
            end
        end
    end

endmodule

// File: doc/tawas_rcn_issue_buf.md
TAWAS_RCN_ISSUE_BUF -- requirements
Module: tawas_rcn_issue_buf

Interface
REQ-001 SHALL have parameter MASTER_ID, default 3'd0: ring master ID stamped into requests and matched on responses.
REQ-002 SHALL have parameter DEPTH, default 4: issue FIFO entries, a power of two, at least 2.
REQ-003 SHALL have clk, input, 1 bit: clock, all state updates on rising edge.
REQ-004 SHALL have rst, input, 1 bit: reset, asynchronous, active-high.
REQ-005 SHALL have cs, input, 1 bit: request strobe, one request per cycle.
REQ-006 SHALL have seq, input, 5 bits: issuing thread, returned as rsp_seq.
REQ-007 SHALL have wr, input, 1 bit: 1 = write, 0 = read.
REQ-008 SHALL have mask, input, 4 bits: byte enables.
REQ-009 SHALL have addr, input, 24 bits: byte address; bits [1:0] are ignored.
REQ-010 SHALL have wdata, input, 32 bits: write data, ignored for reads.
REQ-011 SHALL have full, output, 1 bit: issue backpressure.
REQ-012 SHALL have rdone and wdone, outputs, 1 bit each: one-cycle response pulses.
REQ-013 SHALL have rsp_seq (5 bits), rsp_mask (4 bits), rsp_addr (24 bits, [1:0]=0) and rsp_data (32 bits), outputs: response fields.
REQ-014 SHALL have rcn_in, input, 69 bits: ring ingress.
REQ-015 SHALL have rcn_out, output, 69 bits: ring egress, registered.

Function
REQ-016 Ring word layout SHALL be:
- [68] valid
- [67] pending (1 = request, 0 = response)
- [66] wr
- [65:63] master id
- [62:58] seq
- [57:54] mask
- [53:32] addr[23:2]
- [31:0] data
REQ-017 cs=1 SHALL push {wr, seq, mask, addr[23:2], wdata} into the FIFO at that edge.
REQ-018 full SHALL be 1 whenever occupancy is at least DEPTH-1, combinationally from the count; this gives one cycle of slack for an already-registered cs.
REQ-019 A cs while occupancy equals DEPTH is a protocol violation; the push SHALL be dropped and the FIFO state left unchanged.
REQ-020 Capture: when rcn_in has valid=1, pending=0 and id=MASTER_ID, the word SHALL be consumed and that ring slot treated as empty.
REQ-021 Pass-through: every other valid rcn_in word, including requests carrying this node's own ID, SHALL be copied unchanged to rcn_out at the next edge.
REQ-022 Insert: when the ring slot is empty (rcn_in.valid=0 or captured) and the FIFO is non-empty, the head SHALL be popped and driven to rcn_out at the next edge with valid=1, pending=1 and id=MASTER_ID; otherwise rcn_out SHALL be 0.
REQ-023 Push and pop in the same cycle SHALL leave occupancy unchanged; push into an empty FIFO SHALL NOT pop in the same cycle.
REQ-024 Minimum latency SHALL be one cycle from accepted cs to the word on rcn_out, i.e. at edge N+1 for cs at edge N, given a free slot.
REQ-025 A captured response at edge M SHALL drive, at edge M+1, rdone = ~wr or wdone = wr for exactly one cycle, together with rsp_seq, rsp_mask, rsp_addr={addr,2'b00} and rsp_data.
REQ-026 The rsp_* fields SHALL hold their last value until the next capture.
REQ-027 Read pointer, write pointer and count SHALL wrap modulo DEPTH, with count using log2(DEPTH)+1 bits.

Reset
REQ-028 On reset the FIFO SHALL be empty, full=0, rcn_out=0, rdone=wdone=0, and rsp_* = 0.
REQ-029 Reset mid-operation SHALL discard all queued requests; in-flight ring responses arriving after reset SHALL be captured normally.

Structure
REQ-030 The ring field bit positions and widths SHALL live in a shared tawas_rcn definitions include used by every ring node.
REQ-031 The FIFO SHALL be a sub-module named tawas_rcn_fifo, parameterised by width and DEPTH, exposing push, pop, full, empty and count.

Verification
REQ-032 Idle ring, single read (seq=5, addr=24'h000104, mask=4'hF) -> rcn_out at next edge = {1,1,0,MASTER_ID,5'd5,4'hF,22'h41,32'h0}.
REQ-033 Inject a response with id=MASTER_ID, seq=5, wr=0, data=32'hDEADBEEF -> next cycle rdone=1, rsp_seq=5, rsp_data=32'hDEADBEEF, rcn_out=0; wdone=0.
REQ-034 Ring fully occupied by foreign words while four writes are issued -> full=1 after the third push; all foreign words pass unchanged; the FIFO drains in order once the ring is idle.
REQ-035 Own response arrives in the same cycle the FIFO is non-empty -> the response is captured and the head is inserted into that slot at the next edge.
REQ-036 A request with this node's own ID is injected on rcn_in -> it is passed through unchanged; no rdone or wdone.
REQ-037 rst asserted with 3 entries queued -> full=0 and rcn_out=0 immediately; no queued request ever appears on the ring.
